// File: rtl/gsim_pkg.sv
// Shared GSIM matrix-memory types and sizes used by the fetch front-end.
package gsim_pkg;

  localparam int unsigned MAT_DATA_W      = 256;
  localparam int unsigned MAT_ADDR_W      = 10;
  localparam int unsigned ROWS_PER_MATRIX = 17;
  localparam int unsigned FETCH_DEPTH     = 4;

  typedef logic [MAT_DATA_W-1:0] mat_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/gsim_fetch_fifo.sv
// Circular synchronous FIFO; when empty, dout holds the last word popped.
module gsim_fetch_fifo #(
  parameter int unsigned W     = 256,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [W-1:0]     last;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? last : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        last   <= mem[rd_ptr];
      end
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/gsim_mem_fetch.sv
// In-order credit-based row-read front-end between the GSIM core and matrix memory.
// Define GSIM_FETCH_BYPASS_EN for a 0-cycle path from memory to core when the FIFO is empty.
module gsim_mem_fetch
  import gsim_pkg::*;
#(
  parameter int unsigned DATA_W = MAT_DATA_W,
  parameter int unsigned ADDR_W = MAT_ADDR_W,
  parameter int unsigned DEPTH  = FETCH_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_req_rdy,
  output logic              o_mem_rreq,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_rrdy,
  input  logic [DATA_W-1:0] i_mem_dout,
  input  logic              i_mem_dout_vld,
  output logic [DATA_W-1:0] o_data,
  output logic              o_vld,
  input  logic              i_data_rdy,
  output logic              o_err
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned USED_W = CNT_W + 1;

  fetch_state_t      state, state_n;
  logic              pending, pending_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [CNT_W-1:0]  inflight, inflight_n;
  logic [CNT_W-1:0]  discard, discard_n;
  logic              err, err_n;
  logic [USED_W-1:0] fifo_cnt_n;

  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [USED_W-1:0] used;
  logic              accept, mem_accept;
  logic              rsp_drop, rsp_keep, rsp_stray;
  logic              bypass, push, pop, overflow;

  assign used = USED_W'(pending) + USED_W'(inflight) + USED_W'(fifo_count);
  assign o_req_rdy = !i_reset && !i_flush && (used < USED_W'(DEPTH)) && (!pending || i_mem_rrdy);
  assign accept     = i_req && o_req_rdy;
  assign mem_accept = pending && i_mem_rrdy;

  // DRAIN is held exactly while discard is non-zero.
  assign rsp_drop  = i_mem_dout_vld && (state == DRAIN);
  assign rsp_keep  = i_mem_dout_vld && (state != DRAIN) && (inflight != '0);
  assign rsp_stray = i_mem_dout_vld && (state != DRAIN) && (inflight == '0);

`ifdef GSIM_FETCH_BYPASS_EN
  assign bypass = rsp_keep && fifo_empty && i_data_rdy && !i_flush;
  assign o_vld  = !fifo_empty || bypass;
  assign o_data = bypass ? i_mem_dout : fifo_dout;
`else
  assign bypass = 1'b0;
  assign o_vld  = !fifo_empty;
  assign o_data = fifo_dout;
`endif

  assign push     = rsp_keep && !bypass && !i_flush;
  assign pop      = o_vld && i_data_rdy && !bypass;
  assign overflow = push && fifo_full && !pop;

  assign o_mem_rreq = pending;
  assign o_mem_addr = addr_q;
  assign o_err      = err;

  gsim_fetch_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .reset (i_reset),
    .clear (i_flush),
    .push  (push),
    .din   (i_mem_dout),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      pending  <= 1'b0;
      addr_q   <= '0;
      inflight <= '0;
      discard  <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      pending  <= pending_n;
      addr_q   <= addr_n;
      inflight <= inflight_n;
      discard  <= discard_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    pending_n  = pending;
    addr_n     = addr_q;
    inflight_n = inflight;
    discard_n  = discard;
    err_n      = err;
    fifo_cnt_n = USED_W'(fifo_count);

    if (accept) begin
      pending_n = 1'b1;
      addr_n    = i_addr;
    end else if (mem_accept) begin
      pending_n = 1'b0;
    end

    inflight_n = inflight + CNT_W'(mem_accept) - CNT_W'(rsp_keep);
    if (rsp_drop) discard_n = discard - CNT_W'(1);

    fifo_cnt_n = USED_W'(fifo_count) + USED_W'(push && !overflow) - USED_W'(pop);

    // Everything still owed by memory, including a coincident accept, becomes discard.
    if (i_flush) begin
      pending_n  = 1'b0;
      discard_n  = discard_n + inflight_n;
      inflight_n = '0;
      fifo_cnt_n = '0;
    end

    if (rsp_stray || overflow) err_n = 1'b1;

    if (discard_n != '0)                                          state_n = DRAIN;
    else if (pending_n || (inflight_n != '0) || (fifo_cnt_n != '0)) state_n = BUSY;
    else                                                          state_n = IDLE;
  end

endmodule

// File: tb/tb_gsim_mem_fetch.sv
// Self-checking bench for gsim_mem_fetch: vector table plus scoreboard and memory responder.
module tb_gsim_mem_fetch;
  import gsim_pkg::*;

  localparam int unsigned AW = MAT_ADDR_W;
  localparam int unsigned DW = MAT_DATA_W;

  logic          i_clk = 1'b0;
  logic          i_reset, i_flush, i_req, o_req_rdy, o_mem_rreq, i_mem_rrdy;
  logic [AW-1:0] i_addr, o_mem_addr;
  logic [DW-1:0] i_mem_dout, o_data;
  logic          i_mem_dout_vld, o_vld, i_data_rdy, o_err;

  always #5 i_clk = ~i_clk;

  gsim_mem_fetch dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_flush        (i_flush),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .o_req_rdy      (o_req_rdy),
    .o_mem_rreq     (o_mem_rreq),
    .o_mem_addr     (o_mem_addr),
    .i_mem_rrdy     (i_mem_rrdy),
    .i_mem_dout     (i_mem_dout),
    .i_mem_dout_vld (i_mem_dout_vld),
    .o_data         (o_data),
    .o_vld          (o_vld),
    .i_data_rdy     (i_data_rdy),
    .o_err          (o_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   exp16;
  } vec_t;

  int total = 0;
  int bad   = 0;
  mat_word_t     sb_q[$];
  logic [AW-1:0] mem_q[$];
  bit  mem_hold  = 1'b0;
  bit  stray_inj = 1'b0;
  int  acc_cnt = 0, mem_acc_cnt = 0, pop_cnt = 0;

  function automatic mat_word_t model_word(input logic [AW-1:0] a);
    return {16{16'h1223 + 16'(a)}};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then let the memory model respond after the edge.
  task automatic cyc();
    @(negedge i_clk);
    if (!i_reset) begin
      if (i_flush) sb_q.delete();
      if (i_req && o_req_rdy) begin
        sb_q.push_back(model_word(i_addr));
        acc_cnt++;
      end
      if (o_vld && i_data_rdy) begin
        pop_cnt++;
        check("sb_avail", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) check_word("sb_data", o_data, sb_q.pop_front());
      end
    end
    if (o_mem_rreq && i_mem_rrdy) begin
      mem_q.push_back(o_mem_addr);
      mem_acc_cnt++;
    end
    @(posedge i_clk);
    #1;
    i_mem_dout_vld = 1'b0;
    if (stray_inj) begin
      i_mem_dout_vld = 1'b1;
      i_mem_dout     = {16{16'hDEAD}};
      stray_inj      = 1'b0;
    end else if (!mem_hold && mem_q.size() != 0) begin
      i_mem_dout_vld = 1'b1;
      i_mem_dout     = model_word(mem_q.pop_front());
    end
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 40 && (sb_q.size() != 0 || mem_q.size() != 0); k++) cyc();
    cyc();
    check(name, sb_q.size() + mem_q.size(), 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cyc();
    cyc();
    i_reset = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[5];
    int   base, mbase, pbase;
    logic [AW-1:0] a;

    tab[0] = '{10'h011, 16'h1234};
    tab[1] = '{10'h000, 16'h1223};
    tab[2] = '{10'h3FF, 16'h1622};
    tab[3] = '{10'h155, 16'h1378};
    tab[4] = '{10'h2AA, 16'h14CD};

    i_reset = 1'b1; i_flush = 1'b0; i_req = 1'b1; i_addr = 10'h155;
    i_mem_rrdy = 1'b1; i_mem_dout = '0; i_mem_dout_vld = 1'b0; i_data_rdy = 1'b1;
    cyc();
    cyc();
    check("rst_rreq", int'(o_mem_rreq), 0);
    check("rst_addr", int'(o_mem_addr), 0);
    check("rst_vld", int'(o_vld), 0);
    check_word("rst_data", o_data, '0);
    check("rst_err", int'(o_err), 0);
    check("rst_req_rdy", int'(o_req_rdy), 0);
    i_reset = 1'b0;
    i_req   = 1'b0;
    cyc();

    // Single reads with fixed latency.
    for (int i = 0; i < 5; i++) begin
      i_req  = 1'b1;
      i_addr = tab[i].addr;
      cyc();
      i_req = 1'b0;
      check("rd_rreq_c1", int'(o_mem_rreq), 1);
      check("rd_addr_c1", int'(o_mem_addr), int'(tab[i].addr));
      cyc();
      #1;
      check("rd_rreq_c2", int'(o_mem_rreq), 0);
`ifdef GSIM_FETCH_BYPASS_EN
      check("rd_vld_c2", int'(o_vld), 1);
      check_word("rd_data_c2", o_data, {16{tab[i].exp16}});
      cyc();
      check("rd_vld_c3", int'(o_vld), 0);
`else
      check("rd_vld_c2", int'(o_vld), 0);
      cyc();
      check("rd_vld_c3", int'(o_vld), 1);
      check_word("rd_data_c3", o_data, {16{tab[i].exp16}});
`endif
      cyc();
      check("rd_vld_c4", int'(o_vld), 0);
      check("rd_err", int'(o_err), 0);
    end

    // Back-pressure: credits stop acceptance at DEPTH outstanding.
    i_data_rdy = 1'b0;
    base = acc_cnt;
    a = 10'h100;
    i_req = 1'b1;
    i_addr = a;
    for (int k = 0; k < 10; k++) begin
      int prev;
      prev = acc_cnt;
      cyc();
      if (acc_cnt != prev && (acc_cnt - base) < 6) begin
        a = a + 10'd1;
        i_addr = a;
      end
    end
    #1;
    check("bp_req_rdy", int'(o_req_rdy), 0);
    check("bp_accepts", acc_cnt - base, 4);
    check("bp_vld", int'(o_vld), 1);
    check_word("bp_head", o_data, {16{16'h1323}});
    i_req = 1'b0;
    i_data_rdy = 1'b1;
    pbase = pop_cnt;
    wait_idle("bp_drain");
    check("bp_pops", pop_cnt - pbase, 4);
    check("bp_vld_empty", int'(o_vld), 0);
    check_word("bp_hold_last", o_data, {16{16'h1326}});

    // Memory stall holds the request stable.
    i_mem_rrdy = 1'b0;
    i_req  = 1'b1;
    i_addr = 10'h2AA;
    cyc();
    i_addr = 10'h2AB;
    base  = acc_cnt;
    mbase = mem_acc_cnt;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("st_rreq", int'(o_mem_rreq), 1);
      check("st_addr", int'(o_mem_addr), 32'h2AA);
      check("st_req_rdy", int'(o_req_rdy), 0);
      cyc();
    end
    check("st_no_accept", acc_cnt - base, 0);
    check("st_no_issue", mem_acc_cnt - mbase, 0);
    i_mem_rrdy = 1'b1;
    #1;
    check("st_req_rdy_rise", int'(o_req_rdy), 1);
    cyc();
    i_req = 1'b0;
    check("st_single_issue", mem_acc_cnt - mbase, 1);
    check("st_next_addr", int'(o_mem_addr), 32'h2AB);
    wait_idle("st_drain");

    // Flush with two responses in flight.
    mem_q.delete();
    mem_hold = 1'b1;
    i_req  = 1'b1;
    i_addr = 10'h050;
    cyc();
    i_addr = 10'h051;
    cyc();
    i_req = 1'b0;
    cyc();
    check("fl_inflight", mem_q.size(), 2);
    i_flush = 1'b1;
    i_req   = 1'b1;
    i_addr  = 10'h3FF;
    #1;
    check("fl_req_rdy", int'(o_req_rdy), 0);
    base = acc_cnt;
    cyc();
    i_flush = 1'b0;
    i_req   = 1'b0;
    check("fl_ignored_req", acc_cnt - base, 0);
    mem_hold = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      #1;
      check("fl_vld_low", int'(o_vld), 0);
    end
    check("fl_err", int'(o_err), 0);
    check("fl_drained", mem_q.size(), 0);
    i_req  = 1'b1;
    i_addr = 10'h3FF;
    cyc();
    i_req = 1'b0;
    pbase = pop_cnt;
    wait_idle("fl_new_read");
    check("fl_new_pop", pop_cnt - pbase, 1);
    check("fl_err_after", int'(o_err), 0);

    // Reset mid-operation: the late response becomes a stray.
    mem_q.delete();
    mem_hold = 1'b1;
    i_req  = 1'b1;
    i_addr = 10'h077;
    cyc();
    i_req = 1'b0;
    cyc();
    cyc();
    do_reset();
    check("mr_err_clear", int'(o_err), 0);
    check("mr_rreq", int'(o_mem_rreq), 0);
    mem_hold = 1'b0;
    cyc();
    cyc();
    check("mr_err_set", int'(o_err), 1);
    check("mr_vld", int'(o_vld), 0);

    // Plain stray response is sticky until reset.
    do_reset();
    check("sy_err_clear", int'(o_err), 0);
    stray_inj = 1'b1;
    cyc();
    cyc();
    check("sy_err_set", int'(o_err), 1);
    check("sy_vld", int'(o_vld), 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("sy_err_sticky", int'(o_err), 1);
    end
    i_req  = 1'b1;
    i_addr = 10'h011;
    cyc();
    i_req = 1'b0;
    pbase = pop_cnt;
    wait_idle("sy_read");
    check("sy_read_pop", pop_cnt - pbase, 1);
    check("sy_err_still", int'(o_err), 1);
    do_reset();
    check("sy_err_reset", int'(o_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
